// File: rtl/instr_fetch_buffer_if.sv
// rtl/instr_fetch_buffer_if.sv - instruction stream handshake between fetch buffer and execute stage
//
// Signals:
//   inst_valid  head of the fetch FIFO holds a valid instruction
//   inst_ready  consumer accepts the head this cycle
//   inst        head instruction word
//   inst_pc     PC of the head instruction
// Modports: master = fetch buffer (producer), slave = execute stage (consumer).

interface instr_fetch_buffer_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (output inst_valid, output inst, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst, input inst_pc, output inst_ready);
endinterface

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - byte-serial instruction fetch with {pc, inst} FIFO and redirect
//
// Assembles big-endian 32-bit words from a byte-wide synchronous-read memory
// (4 reads per word) and queues them with their PC for the execute stage.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   imem_rd/imem_addr byte read strobe and address (data returns next cycle)
//   imem_rdata        returned byte
//   redirect/_pc      flush everything and restart fetch at redirect_pc & ~3
//   inst_if           instruction stream (master modport)
//   fifo_count        occupied FIFO entries
//   stall_cycles      only with IFB_STALL_COUNT_EN: saturating count of cycles
//                     with no valid instruction presented

module instr_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_rd,
    output logic [IMEM_AW-1:0]       imem_addr,
    input  logic [7:0]               imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    instr_fetch_buffer_if.master     inst_if,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef IFB_STALL_COUNT_EN
    ,
    output logic [15:0]              stall_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    logic [1:0]    k;
    logic [31:0]   fetch_pc;
    logic          word_inflight;

    logic          rd_valid;
    logic [1:0]    rd_k;
    logic [31:0]   rd_pc;
    logic [23:0]   asm_hi;

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [CW:0]   used;
    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    // A word may only start when a FIFO slot is reserved for it, counting a
    // word that is still being assembled; this guarantees no in-flight word is lost.
    assign used      = {1'b0, count} + (CW+1)'(word_inflight);
    assign credit_ok = used < (CW+1)'(DEPTH);

    // Byte 0 is issued in the same cycle the credit check passes, so a word
    // starts without an idle bubble; the remaining bytes follow unconditionally.
    assign issue     = !reset && !redirect && ((state == ISSUE) || credit_ok);
    assign imem_rd   = issue;
    assign imem_addr = reset ? '0 : {fetch_pc[IMEM_AW-1:2], k};

    assign push = rd_valid && (rd_k == 2'd3);
    assign pop  = (count != '0) && inst_if.inst_ready;

    assign fifo_count         = count;
    assign inst_if.inst_valid = (count != '0);
    assign inst_if.inst       = (count != '0) ? mem_inst[rd_ptr] : 32'h0;
    assign inst_if.inst_pc    = (count != '0) ? mem_pc[rd_ptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            k             <= 2'd0;
            fetch_pc      <= RESET_PC;
            word_inflight <= 1'b0;
            rd_valid      <= 1'b0;
            rd_k          <= 2'd0;
            rd_pc         <= 32'h0;
            asm_hi        <= 24'h0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else if (redirect) begin
            state         <= IDLE;
            k             <= 2'd0;
            fetch_pc      <= {redirect_pc[31:2], 2'b00};
            word_inflight <= 1'b0;
            rd_valid      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            rd_valid <= issue;
            rd_k     <= k;
            rd_pc    <= fetch_pc;

            if (issue) begin
                if (k == 2'd3) begin
                    k        <= 2'd0;
                    fetch_pc <= fetch_pc + 32'd4;
                    state    <= IDLE;
                end else begin
                    k     <= k + 2'd1;
                    state <= ISSUE;
                end
            end

            if (issue && (k == 2'd0))
                word_inflight <= 1'b1;
            else if (push)
                word_inflight <= 1'b0;

            if (rd_valid) begin
                case (rd_k)
                    2'd0:    asm_hi[23:16] <= imem_rdata;
                    2'd1:    asm_hi[15:8]  <= imem_rdata;
                    2'd2:    asm_hi[7:0]   <= imem_rdata;
                    default: ;
                endcase
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count/rd_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= {asm_hi, imem_rdata};
            mem_pc[wr_ptr]   <= rd_pc;
        end
    end

`ifdef IFB_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= 16'h0;
        else if (!inst_if.inst_valid && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - self-checking bench for instr_fetch_buffer

module tb_instr_fetch_buffer;

    localparam int DEPTH   = 4;
    localparam int IMEM_AW = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_rd;
    logic [6:0]  imem_addr;
    logic [7:0]  imem_rdata = 8'h0;
    logic [2:0]  fifo_count;
`ifdef IFB_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    instr_fetch_buffer_if ifb();

    instr_fetch_buffer #(.DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_if     (ifb),
        .fifo_count  (fifo_count)
`ifdef IFB_STALL_COUNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:127];

    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [6:0] a;
        a = pc[6:0];
        return {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]};
    endfunction

    // Reference model: the accepted stream must be consecutive word PCs from the
    // last reset/redirect target, each carrying the big-endian memory word.
    logic [31:0] exp_pc = 32'h0;
    int          pop_count = 0;
    logic        mon_en = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] hold_inst, hold_pc;
`ifdef IFB_STALL_COUNT_EN
    int          stall_model = 0;
    logic        stall_ok = 1'b0;
`endif

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold && ifb.inst_valid) begin
                check("hold_inst", ifb.inst, hold_inst);
                check("hold_pc", ifb.inst_pc, hold_pc);
            end
            check("count_le_depth", fifo_count <= 3'(DEPTH), 1'b1);
            check("valid_vs_count", ifb.inst_valid, fifo_count != 3'd0);
        end
`ifdef IFB_STALL_COUNT_EN
        if (stall_ok) check("stall_cycles", stall_cycles, stall_model);
        if (reset) begin
            stall_model = 0;
            stall_ok    = 1'b1;
        end else if (!ifb.inst_valid && stall_model < 65535) begin
            stall_model++;
        end
`endif
        hold = 1'b0;
        if (reset) begin
            exp_pc = 32'h0;
        end else if (redirect) begin
            exp_pc = redirect_pc & ~32'h3;
        end else if (ifb.inst_valid && ifb.inst_ready) begin
            check("pop_pc", ifb.inst_pc, exp_pc);
            check("pop_inst", ifb.inst, word_at(exp_pc));
            exp_pc    = exp_pc + 32'd4;
            pop_count++;
        end else if (ifb.inst_valid) begin
            hold      = 1'b1;
            hold_inst = ifb.inst;
            hold_pc   = ifb.inst_pc;
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the edge that starts cycle 1.
    task automatic do_reset;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int target;
        int i;
        target = pop_count + n;
        i = 0;
        while (pop_count < target && i < budget) begin
            next_cycle();
            i++;
        end
        check(tag, pop_count >= target, 1'b1);
    endtask

    initial begin
        int  i;
        logic found;
        logic rd_late;
        logic [7:0] init_bytes [8];
        init_bytes = '{8'h8C, 8'h04, 8'h00, 8'h00, 8'h00, 8'h85, 8'h30, 8'h20};
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 8; a++) mem[a] = init_bytes[a];
        ifb.inst_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_rd", imem_rd, 1'b0);
        check("rst_imem_addr", imem_addr, 7'h0);
        check("rst_inst_valid", ifb.inst_valid, 1'b0);
        check("rst_inst", ifb.inst, 32'h0);
        check("rst_inst_pc", ifb.inst_pc, 32'h0);
        check("rst_fifo_count", fifo_count, 3'd0);
        mon_en = 1'b1;

        // Cold start latency
        ifb.inst_ready = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int kk = 0; kk < 4; kk++) begin
            @(negedge clk);
            check("cold_rd", imem_rd, 1'b1);
            check("cold_addr", imem_addr, 7'(kk));
            next_cycle();
        end
        @(negedge clk);
        check("cold_c5_valid", ifb.inst_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("cold_c6_valid", ifb.inst_valid, 1'b1);
        check("cold_inst0", ifb.inst, 32'h8C040000);
        check("cold_pc0", ifb.inst_pc, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            next_cycle();
            @(negedge clk);
            if (ifb.inst_valid) found = 1'b1;
        end
        check("cold_second_seen", found, 1'b1);
        check("cold_inst1", ifb.inst, 32'h00853020);
        check("cold_pc1", ifb.inst_pc, 32'h4);

        // Backpressure
        ifb.inst_ready = 1'b0;
        do_reset();
        rd_late = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c >= 20 && imem_rd) rd_late = 1'b1;
            next_cycle();
        end
        @(negedge clk);
        check("bp_count_full", fifo_count, 3'd4);
        check("bp_no_issue_full", rd_late, 1'b0);
        check("bp_head_pc", ifb.inst_pc, 32'h0);
        ifb.inst_ready = 1'b1;
        wait_pops(4, 40, "bp_drain");

        // Redirect during byte 2 of the word at pc 8
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (imem_rd && imem_addr == 7'h09) found = 1'b1;
            else next_cycle();
        end
        check("redir_found_k1", found, 1'b1);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h22;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("redir_valid_r1", ifb.inst_valid, 1'b0);
        check("redir_count_r1", fifo_count, 3'd0);
        check("redir_rd_r1", imem_rd, 1'b1);
        check("redir_addr_r1", imem_addr, 7'h20);
        wait_pops(2, 40, "redir_progress");

        // Push and pop in the same cycle with two entries held
        ifb.inst_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (fifo_count == 3'd2 && imem_rd && imem_addr[1:0] == 2'd3) found = 1'b1;
            else next_cycle();
        end
        check("pp_found", found, 1'b1);
        next_cycle();
        ifb.inst_ready = 1'b1;
        next_cycle();
        ifb.inst_ready = 1'b0;
        @(negedge clk);
        check("pp_count_kept", fifo_count, 3'd2);
        ifb.inst_ready = 1'b1;
        wait_pops(3, 40, "pp_drain");

        // Memory address wrap
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h7C;
        next_cycle();
        redirect = 1'b0;
        i = pop_count;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("wrap_rd", imem_rd, 1'b1);
            check("wrap_addr", imem_addr, 7'((32'h7C + c) & 32'h7F));
            next_cycle();
        end
        wait_pops(2, 40, "wrap_pops");
        check("wrap_pc_next", exp_pc >= 32'h84, 1'b1);

        // Reset with simultaneous redirect while fetching
        next_cycle();
        next_cycle();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("rr_imem_rd", imem_rd, 1'b0);
        check("rr_imem_addr", imem_addr, 7'h0);
        check("rr_valid", ifb.inst_valid, 1'b0);
        check("rr_inst", ifb.inst, 32'h0);
        check("rr_inst_pc", ifb.inst_pc, 32'h0);
        check("rr_count", fifo_count, 3'd0);
`ifdef IFB_STALL_COUNT_EN
        check("rr_stall_zero", stall_cycles, 16'h0);
`endif
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rr_restart_rd", imem_rd, 1'b1);
        check("rr_restart_addr", imem_addr, 7'h0);

        // Randomized traffic
        i = pop_count;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            ifb.inst_ready = ($urandom_range(3) != 0);
            redirect       = ($urandom_range(49) == 0);
            redirect_pc    = $urandom;
        end
        next_cycle();
        redirect       = 1'b0;
        ifb.inst_ready = 1'b1;
        repeat (40) next_cycle();
        check("random_progress", pop_count > i + 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
